produto_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter sitting directly downstream of the 4-bit multiplier. It captures the 8-bit product `P` on a start request and converts it with an iterative shift-and-add-3 (double dabble) algorithm, one bit per clock. It presents hundreds, tens and units digits to the display stage, with a busy/done handshake.

---
 rtl/produto_bcd_seq.sv | 90 +++++++++
 tb/tb_produto_bcd_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/produto_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clock).
// Captures the multiplier product on start and presents registered digits with a busy/done handshake.
module produto_bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] P,
  output logic       busy,
  output logic       done,
  output logic [3:0] centenas,
  output logic [3:0] dezenas,
  output logic [3:0] unidades
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [2:0]  cnt;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_nxt;
  logic [7:0]  bin_nxt;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    bcd_nxt = (bcd_adj << 1) | 12'(bin[7]);
    bin_nxt = bin << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Digits are loaded from the post-shift value on the 8th shift only, so they never show scratch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      centenas <= '0;
      dezenas  <= '0;
      unidades <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin <= P;
            bcd <= '0;
            cnt <= '0;
          end
        end
        CONV: begin
          bin <= bin_nxt;
          bcd <= bcd_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            centenas <= bcd_nxt[11:8];
            dezenas  <= bcd_nxt[7:4];
            unidades <= bcd_nxt[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CONV);
  assign done = (state == DONE);

endmodule

// File: tb/tb_produto_bcd_seq.sv
// Self-checking bench for produto_bcd_seq: directed vector table, multi-cycle corner sequences
// and a full 0..255 sweep against a divide/modulo reference.
module tb_produto_bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] P;
  logic       busy;
  logic       done;
  logic [3:0] centenas;
  logic [3:0] dezenas;
  logic [3:0] unidades;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic [7:0] p;
    int         c;
    int         d;
    int         u;
  } vec_t;

  vec_t vecs[6];

  produto_bcd_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .P        (P),
    .busy     (busy),
    .done     (done),
    .centenas (centenas),
    .dezenas  (dezenas),
    .unidades (unidades)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkDigits(input string name, input int c, input int d, input int u);
    checkOutput({name, " centenas"}, int'(centenas), c);
    checkOutput({name, " dezenas"},  int'(dezenas),  d);
    checkOutput({name, " unidades"}, int'(unidades), u);
  endtask

  // One full conversion from IDLE; checks busy for 8 cycles, the done pulse and the return to IDLE
  task automatic applyStimulus(input logic [7:0] p, input int c, input int d, input int u);
    P     = p;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("busy cyc%0d p%0d", i, p), int'(busy), 1);
      checkOutput($sformatf("done cyc%0d p%0d", i, p), int'(done), 0);
      tick();
    end
    checkOutput($sformatf("done pulse p%0d", p), int'(done), 1);
    checkOutput($sformatf("busy at done p%0d", p), int'(busy), 0);
    checkDigits($sformatf("p%0d", p), c, d, u);
    checkOutput($sformatf("digit range p%0d", p),
                int'(centenas <= 4'd2 && dezenas <= 4'd9 && unidades <= 4'd9), 1);
    tick();
    checkOutput($sformatf("done after p%0d", p), int'(done), 0);
    checkOutput($sformatf("busy after p%0d", p), int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{p: 8'd0,   c: 0, d: 0, u: 0};
    vecs[1] = '{p: 8'd225, c: 2, d: 2, u: 5};
    vecs[2] = '{p: 8'd255, c: 2, d: 5, u: 5};
    vecs[3] = '{p: 8'd99,  c: 0, d: 9, u: 9};
    vecs[4] = '{p: 8'd100, c: 1, d: 0, u: 0};
    vecs[5] = '{p: 8'd9,   c: 0, d: 0, u: 9};

    rst_n = 1'b0;
    start = 1'b0;
    P     = 8'd0;
    repeat (3) tick();
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkDigits("reset", 0, 0, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) applyStimulus(vecs[i].p, vecs[i].c, vecs[i].d, vecs[i].u);

    // Extra start pulses during CONV and DONE are dropped, P changes after capture are ignored
    P     = 8'd57;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      start = (c == 3 || c == 9);
      P     = 8'(c * 13);
      checkOutput($sformatf("ignore busy cyc%0d", c), int'(busy), int'(c <= 8));
      checkOutput($sformatf("ignore done cyc%0d", c), int'(done), int'(c == 9));
      if (c >= 9) checkDigits($sformatf("ignore cyc%0d", c), 0, 5, 7);
      tick();
    end
    start = 1'b0;

    for (int p = 0; p <= 255; p++) applyStimulus(8'(p), p / 100, (p / 10) % 10, p % 10);

    // Reset mid-conversion aborts with no done and clears the previously held 2/5/5 digits
    P     = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      rst_n = (c != 5);
      checkOutput($sformatf("abort busy cyc%0d", c), int'(busy), int'(c <= 5));
      checkOutput($sformatf("abort done cyc%0d", c), int'(done), 0);
      if (c >= 6) checkDigits($sformatf("abort cyc%0d", c), 0, 0, 0);
      tick();
    end
    rst_n = 1'b1;

    // start held high: back-to-back conversions ten cycles apart, P swapped right after first capture
    P     = 8'd37;
    start = 1'b1;
    tick();
    P = 8'd142;
    for (int c = 1; c <= 19; c++) begin
      int m;
      m = c % 10;
      checkOutput($sformatf("b2b busy cyc%0d", c), int'(busy), int'(m >= 1 && m <= 8));
      checkOutput($sformatf("b2b done cyc%0d", c), int'(done), int'(m == 9));
      if (c < 9)       checkDigits($sformatf("b2b cyc%0d", c), 0, 0, 0);
      else if (c < 19) checkDigits($sformatf("b2b cyc%0d", c), 0, 3, 7);
      else             checkDigits($sformatf("b2b cyc%0d", c), 1, 4, 2);
      tick();
    end
    start = 1'b0;
    tick();
    tick();
    checkOutput("b2b final busy", int'(busy), 0);
    checkDigits("b2b final", 1, 4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
